display_share_arbiter: RTL and testbench
========================================

Name: display_share_arbiter

Overview:
- Shares the 8-digit seven-segment display between NUM_REQ requesters, e.g. score, timer and debug units.
- Each requester offers an 8-digit BCD word with a valid/ready handshake. A round-robin arbiter grants the display, and a dwell counter holds each accepted word for a minimum time.
- Drives the BCD digit inputs and per-digit blank inputs of the display control block. Optional leading-zero blanking.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DWELL, 8, minimum cycles an accepted word is displayed before another is accepted (>=1).
- LZ_BLANK, 1, 1 = blank leading zero digits; digit 0 is never blanked by this rule.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  bit i: requester i offers a word.
- req_bcd  input  32*NUM_REQ  requester i word at [32*i +: 32]; nibble k = digit k.
- req_ready  output  NUM_REQ  one-hot or zero; transfer on rising edge when req_valid[i] & req_ready[i].
- BCD9, BCD8, BCD7, BCD6  output  4 each  digits 7..4 of the displayed word.
- BCD3, BCD2, BCD1, BCD0  output  4 each  digits 3..0 of the displayed word.
- blank  output  8  bit j = 1 darkens digit j; bits 0-3 map to HEX0-3, bits 4-7 map to HEX6-9.
- owner  output  3  index of the requester whose word is displayed.
- showing  output  1  1 once any word has been accepted since reset.

Behaviour:
- Reset (asynchronous, reset_L=0): state EMPTY; all BCD outputs 0; blank=8'hFF; owner=0; showing=0; dwell counter 0; round-robin pointer such that requester 0 has top priority. Reset mid-dwell abandons the word immediately.
- FSM states:
  - EMPTY: nothing shown yet.
  - DWELL: word shown, counter running.
  - OPEN: word retained, new word may be accepted.
- req_ready is combinational. It is nonzero only in EMPTY or OPEN, when some req_valid is high. In that case it is one-hot at the round-robin winner.
  - Winner: the first valid index searched upward (with wrap) from last_grant+1.
- Accept edge (any valid & ready):
  - Latch req_bcd of the winner into the display register; owner = winner; last_grant = winner; showing=1.
  - Counter loads DWELL-1; next state DWELL.
  - New digits appear on the outputs the cycle after the accept edge (registered, latency 1).
- DWELL: counter decrements each cycle; req_ready=0. When the counter is 0, next state is OPEN.
  - With DWELL=1, the state goes straight to OPEN after the accept edge.
  - Net rule: after an accept at edge t, the earliest next accept is at edge t+DWELL.
- OPEN: display unchanged; stays OPEN until a valid appears, then accepts in the same cycle. No idle cycle is required between back-to-back words.
- Requester dropping valid before it is granted is legal; it is simply not selected. Words are never accepted partially.
- Simultaneous valids: exactly one is granted per accept. A continuously valid requester is granted at least once every NUM_REQ accepts.
- blank generation (combinational from the display register):
  - EMPTY: 8'hFF.
  - LZ_BLANK=0: 8'h00.
  - LZ_BLANK=1: digit j is blanked iff every digit k>=j is 4'h0 and j>0.
  - Non-BCD nibbles (A-F) count as nonzero. The downstream digit block shows them dark.
- Counter width $clog2(DWELL)+1 bits, unsigned, no wrap: the counter never decrements below 0.

Decomposition:
- Shared package display_pkg: NUM_DIGITS=8, typedef digit_t (logic [3:0]), typedef word_t (logic [31:0]), enum disp_state_t {EMPTY, DWELL, OPEN}.
- Sub-module rr_arbiter (params N), with:
  - inputs: req, enable, last_grant;
  - outputs: one-hot grant and grant index;
  - combinational only.
- The FSM, dwell counter, display register and blank logic stay in display_share_arbiter.

Test Plan (NUM_REQ=4, DWELL=8, LZ_BLANK=1):
- Reset, no requests -> blank=8'hFF, BCD*=0, showing=0, req_ready=0; reset_L asserted mid-cycle forces these immediately.
- req_valid=4'b0001, word 32'h0000_0042 -> req_ready=4'b0001 same cycle. Next cycle: BCD1=4, BCD0=2, blank=8'hFC, owner=0, showing=1.
- All four valid continuously -> grants 0,1,2,3,0 at edges t, t+8, t+16, t+24, t+32; req_ready=0 on all intervening cycles.
- Word 32'h0000_0000 accepted -> blank=8'hFE (only digit 0 lit); word 32'h1000_0000 -> blank=8'h00.
- Requester 2 valid during DWELL, then dropped before OPEN -> no accept; display retained; state stays OPEN.
- Accept at t, reset_L=0 at t+3 -> outputs return to reset values. After release, requester 0 has top priority again over requester 3.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types for the seven-segment display sharing block
package display_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [3:0]  digit_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    DWELL = 2'd1,
    OPEN  = 2'd2
  } disp_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts after last_grant
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic          enable,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    // k=N revisits last_grant itself, so a lone requester can win repeatedly
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/display_share_arbiter.sv
// rtl/display_share_arbiter.sv - round-robin sharing of the 8-digit display with minimum dwell
module display_share_arbiter
  import display_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DWELL    = 8,
  parameter int LZ_BLANK = 1
) (
  input  logic                 clock,
  input  logic                 reset_L,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [32*NUM_REQ-1:0] req_bcd,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [3:0]           BCD9,
  output logic [3:0]           BCD8,
  output logic [3:0]           BCD7,
  output logic [3:0]           BCD6,
  output logic [3:0]           BCD3,
  output logic [3:0]           BCD2,
  output logic [3:0]           BCD1,
  output logic [3:0]           BCD0,
  output logic [7:0]           blank,
  output logic [2:0]           owner,
  output logic                 showing
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(DWELL) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

  disp_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  word_t         disp_q;
  word_t         sel_word;
  logic [IW-1:0] owner_q, last_q;
  logic          showing_q;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic          accept;
  logic          arb_enable;
  logic          zero_above;

  assign arb_enable = (state_q != display_pkg::DWELL);

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req        (req_valid),
    .enable     (arb_enable),
    .last_grant (last_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign sel_word  = req_bcd[32*int'(grant_idx) +: 32];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      EMPTY, OPEN: begin
        if (accept) begin
          cnt_d   = CNT_LOAD;
          state_d = (DWELL == 1) ? OPEN : display_pkg::DWELL;
        end
      end
      display_pkg::DWELL: begin
        // leave on the edge that would bring the counter to zero so the
        // next accept lands exactly DWELL edges after the previous one
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = OPEN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= EMPTY;
      cnt_q     <= '0;
      disp_q    <= '0;
      owner_q   <= '0;
      last_q    <= IW'(NUM_REQ - 1);
      showing_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        disp_q    <= sel_word;
        owner_q   <= grant_idx;
        last_q    <= grant_idx;
        showing_q <= 1'b1;
      end
    end
  end

  assign BCD0    = disp_q[3:0];
  assign BCD1    = disp_q[7:4];
  assign BCD2    = disp_q[11:8];
  assign BCD3    = disp_q[15:12];
  assign BCD6    = disp_q[19:16];
  assign BCD7    = disp_q[23:20];
  assign BCD8    = disp_q[27:24];
  assign BCD9    = disp_q[31:28];
  assign owner   = 3'(owner_q);
  assign showing = showing_q;

  // digit j goes dark only when it and every higher digit are zero
  always_comb begin
    blank      = 8'h00;
    zero_above = 1'b1;
    if (state_q == EMPTY) begin
      blank = 8'hFF;
    end else if (LZ_BLANK != 0) begin
      for (int j = NUM_DIGITS - 1; j >= 1; j--) begin
        zero_above = zero_above & (disp_q[4*j +: 4] == 4'h0);
        blank[j]   = zero_above;
      end
    end
  end

endmodule

// File: tb/tb_display_share_arbiter.sv
// tb/tb_display_share_arbiter.sv - scoreboard bench for display_share_arbiter
module tb_display_share_arbiter;

  logic         clock;
  logic         reset_L;
  logic [3:0]   req_valid;
  logic [127:0] req_bcd;
  logic [3:0]   req_ready;
  logic [3:0]   BCD9, BCD8, BCD7, BCD6, BCD3, BCD2, BCD1, BCD0;
  logic [7:0]   blank;
  logic [2:0]   owner;
  logic         showing;

  typedef struct {
    logic [3:0]  ready;
    logic [31:0] word;
    logic [7:0]  blank;
    logic [2:0]  owner;
    int          gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  display_share_arbiter #(.NUM_REQ(4), .DWELL(8), .LZ_BLANK(1)) dut (
    .clock     (clock),
    .reset_L   (reset_L),
    .req_valid (req_valid),
    .req_bcd   (req_bcd),
    .req_ready (req_ready),
    .BCD9      (BCD9),
    .BCD8      (BCD8),
    .BCD7      (BCD7),
    .BCD6      (BCD6),
    .BCD3      (BCD3),
    .BCD2      (BCD2),
    .BCD1      (BCD1),
    .BCD0      (BCD0),
    .blank     (blank),
    .owner     (owner),
    .showing   (showing)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] shown();
    return {BCD9, BCD8, BCD7, BCD6, BCD3, BCD2, BCD1, BCD0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic push(input logic [3:0] rdy, input logic [31:0] w, input logic [7:0] b,
                      input logic [2:0] o, input int gap);
    exp_t e;
    e.ready = rdy; e.word = w; e.blank = b; e.owner = o; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_accept(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (|(req_ready & req_valid)) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 32'(ok), 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_L = 1'b1;
  endtask

  // monitor: every grant is matched against the next expected accept
  initial begin
    int   last_acc;
    exp_t e;
    last_acc = 0;
    forever begin
      @(negedge clock);
      if (reset_L && req_ready != 4'b0000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 32'(req_ready), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("req_ready", 32'(req_ready), 32'(e.ready));
          if (e.gap > 0) chk("accept_gap", 32'(cyc - last_acc), 32'(e.gap));
          last_acc = cyc;
          @(negedge clock);
          chk("bcd", shown(), e.word);
          chk("blank", 32'(blank), 32'(e.blank));
          chk("owner", 32'(owner), 32'(e.owner));
          chk("showing", 32'(showing), 32'd1);
        end
      end
    end
  end

  initial begin
    reset_L   = 1'b0;
    req_valid = 4'b0000;
    req_bcd   = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_blank", 32'(blank), 32'hFF);
    chk("rst_bcd", shown(), 32'h0);
    chk("rst_showing", 32'(showing), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    @(posedge clock);
    #1 reset_L = 1'b1;

    // single requester, leading-zero blanking
    req_bcd[31:0] = 32'h0000_0042;
    push(4'b0001, 32'h0000_0042, 8'hFC, 3'd0, 0);
    req_valid = 4'b0001;
    wait_accept("acc_0x42");
    req_valid = 4'b0000;
    repeat (10) @(posedge clock);
    #1 do_reset();

    // all valid: round robin 0,1,2,3,0 spaced by the dwell
    req_bcd = {32'h00AB_0000, 32'h0000_0305, 32'h1000_0000, 32'h0000_0000};
    push(4'b0001, 32'h0000_0000, 8'hFE, 3'd0, 0);
    push(4'b0010, 32'h1000_0000, 8'h00, 3'd1, 8);
    push(4'b0100, 32'h0000_0305, 8'hF8, 3'd2, 8);
    push(4'b1000, 32'h00AB_0000, 8'hC0, 3'd3, 8);
    push(4'b0001, 32'h0000_0000, 8'hFE, 3'd0, 8);
    req_valid = 4'b1111;
    repeat (5) wait_accept("acc_rr");

    // requester 2 offers only during dwell, then withdraws
    req_valid = 4'b0100;
    repeat (3) @(posedge clock);
    #1 req_valid = 4'b0000;
    repeat (12) @(posedge clock);
    @(negedge clock);
    chk("drop_ready", 32'(req_ready), 32'd0);
    chk("drop_bcd", shown(), 32'h0);
    chk("drop_blank", 32'(blank), 32'hFE);
    chk("drop_owner", 32'(owner), 32'd0);
    chk("drop_showing", 32'(showing), 32'd1);
    @(posedge clock);
    #1;
    push(4'b0100, 32'h0000_0305, 8'hF8, 3'd2, 0);
    req_valid = 4'b0100;
    wait_accept("acc_open");
    req_valid = 4'b0000;

    // reset three edges into a dwell
    repeat (3) @(posedge clock);
    #3 reset_L = 1'b0;
    #1;
    chk("mid_rst_bcd", shown(), 32'h0);
    chk("mid_rst_blank", 32'(blank), 32'hFF);
    chk("mid_rst_showing", 32'(showing), 32'd0);
    chk("mid_rst_owner", 32'(owner), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_L = 1'b1;

    req_bcd[31:0]   = 32'h0000_0042;
    req_bcd[127:96] = 32'h00AB_0000;
    push(4'b0001, 32'h0000_0042, 8'hFC, 3'd0, 0);
    push(4'b1000, 32'h00AB_0000, 8'hC0, 3'd3, 8);
    req_valid = 4'b1001;
    repeat (2) wait_accept("acc_after_rst");
    req_valid = 4'b0000;

    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clock);
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
